vacc_ctrl: RTL and testbench
============================

Name: vacc_ctrl

Overview:
- Vector accumulator controller. It sums ACC_LEN successive input vectors bin-by-bin, where a vector is 2**ADDR samples.
- Running sums live in an external true dual-port RAM: port A is read-only, port B is write-only.
- The block sits directly upstream of that RAM and drives its address, write-enable and data lines. It consumes the RAM's registered read data, 1-cycle latency.
- At the end of each integration it streams out the final sums.

Parameters:
- IN_W, 8, signed input sample width.
- OUT_W, 16, signed accumulator/output width; must equal the RAM DATA width; OUT_W >= IN_W.
- ADDR, 6, log2 vector length; minimum 2, so no read/write address collision is possible.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  synchronous, active-low reset.
- sync_in  in  1  pulse; arms a new integration.
- acc_len  in  32  vectors per integration; latched on sync_in; 0 is treated as 1.
- din_valid  in  1  input sample strobe; bubbles allowed.
- din  in  IN_W  signed sample.
- ram_a_addr  out  ADDR  RAM port A read address.
- ram_a_dout  in  OUT_W  RAM port A read data; valid 1 cycle after address.
- ram_b_wr  out  1  RAM port B write enable.
- ram_b_addr  out  ADDR  RAM port B write address.
- ram_b_din  out  OUT_W  RAM port B write data.
- dout  out  OUT_W  accumulated bin value.
- dout_valid  out  1  dout qualifier.
- dout_last  out  1  marks the final bin of a dumped integration.
- ovf  out  1  sticky overflow for the integration being dumped; valid with dout_valid.
- acc_cnt  out  32  completed integrations since reset.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - ram_b_wr, dout, dout_valid, dout_last, ovf, acc_cnt, ram_b_addr, ram_b_din and all counters go to 0.
  - In-flight pipeline contents are dropped.
  - RAM contents are not cleared; the first vector overwrites them.
- States:
  - IDLE: din is ignored and no writes occur. sync_in moves to RUN.
  - RUN: accumulates. sync_in in RUN restarts (see below).
- Counters:
  - idx (ADDR bits) and vec (32 bits) advance only on din_valid in RUN.
  - idx wraps from 2**ADDR-1 to 0, and vec increments on that wrap.
  - When vec reaches acc_len_latched-1 and idx wraps, vec returns to 0 (next integration, no sync needed).
- sync_in:
  - Latches acc_len and zeroes idx and vec.
  - The first din_valid strictly after the sync cycle is bin 0 of the first vector.
  - A din_valid sample coincident with sync_in is discarded.
  - Mid-integration sync aborts: the partial integration produces no dout, and writes already in the pipeline still complete.
- Pipeline (sample accepted at cycle t):
  - t: ram_a_addr = idx, driven combinationally. Sample and first/last flags are registered.
  - t+1: ram_a_dout is valid. sum = first ? sext(din) : ram_a_dout + sext(din), modulo 2**OUT_W. Result is registered.
  - t+2: ram_b_wr=1, ram_b_addr=idx, ram_b_din=sum.
  - t+2, if last vector: dout=sum, dout_valid=1, dout_last=(idx==2**ADDR-1).
  - Latency from din_valid to dout_valid is 2 cycles. Throughput is 1 sample per cycle.
- acc_len=1: every vector is both first and last, so dout = sext(din).
- Overflow and completion:
  - Signed overflow of any add in the integration sets that bin's sticky flag. The flag is held per integration (single global sticky bit) and cleared at the first vector's write.
  - ovf on dout equals the sticky value including the current add.
  - acc_cnt increments in the cycle dout_last is asserted.
- Hazard: the same bin is read again no earlier than t+4, and its write commits at the end of t+2. Therefore no forwarding is needed, given ADDR >= 2.

Decomposition:
- Package vacc_pkg holds:
  - state enum {IDLE, RUN};
  - localparam VEC_LEN = 2**ADDR;
  - the sign-extend helper function.
- One sub-module, vacc_counters: idx/vec counters plus first/last flag generation, with inputs sync/valid/acc_len.
- Adder pipeline and output registers stay in the top module.

Test Plan:
1. ADDR=2, IN_W=8, OUT_W=16, sync, acc_len=1, vector 1,2,3,4 -> dout 1,2,3,4 two cycles after each din_valid; dout_last on 4; acc_cnt=1; ovf=0.
2. acc_len=3, three vectors of all 5, RAM preloaded with 0x7777 -> dout 15,15,15,15 only after the 3rd vector; stale RAM is ignored.
3. acc_len=2, din=-128 throughout -> dout 0xFF00 (-256) for all 4 bins.
4. acc_len=300, din=127 -> dout -27436 (38100 mod 2**16), ovf=1; following integration with din=1 -> ovf=0.
5. acc_len=2, sync_in again after 2 samples of vector 2 -> no dout for the aborted integration; next integration starts at bin 0 and dumps correctly.
6. Random din_valid bubbles (50%) with scenario 2 stimulus -> identical dout sequence.
7. rst_n low mid-integration -> all outputs 0 next edge; din ignored until a new sync_in.

Source files
------------

// File: rtl/vacc_pkg.sv
// Shared types and helpers for the vector accumulator controller.
package vacc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int ADDR_DEF = 6;
    localparam int VEC_LEN  = 2 ** ADDR_DEF;

    // Sign-extend the low w bits of v to 64 bits.
    function automatic logic [63:0] sext(input logic [63:0] v, input int w);
        logic signed [63:0] t;
        t = $signed(v << (64 - w));
        return t >>> (64 - w);
    endfunction

endpackage

// File: rtl/vacc_counters.sv
// Bin/vector counters with first/last-vector flags for the accumulator.
module vacc_counters
    import vacc_pkg::*;
#(
    parameter int ADDR = ADDR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sync,
    input  logic            valid,
    input  logic [31:0]     acc_len,
    output logic [ADDR-1:0] idx,
    output logic            first,
    output logic            last,
    output logic            idx_last
);

    localparam int VLEN = (ADDR == ADDR_DEF) ? VEC_LEN : 2 ** ADDR;

    logic [31:0] vec;
    logic [31:0] len;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= '0;
            vec <= '0;
            len <= 32'd1;
        end else if (sync) begin
            idx <= '0;
            vec <= '0;
            len <= (acc_len == 32'd0) ? 32'd1 : acc_len;
        end else if (valid) begin
            idx <= idx + 1'b1;
            if (idx_last) begin
                vec <= last ? 32'd0 : vec + 32'd1;
            end
        end
    end

    always_comb begin
        first    = (vec == 32'd0);
        last     = (vec == len - 32'd1);
        idx_last = (idx == ADDR'(VLEN - 1));
    end

endmodule

// File: rtl/vacc_ctrl.sv
// Vector accumulator controller: read-modify-write of running sums in an
// external dual-port RAM, streaming the final vector of each integration.
module vacc_ctrl
    import vacc_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int ADDR  = ADDR_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_in,
    input  logic [31:0]      acc_len,
    input  logic             din_valid,
    input  logic [IN_W-1:0]  din,
    output logic [ADDR-1:0]  ram_a_addr,
    input  logic [OUT_W-1:0] ram_a_dout,
    output logic             ram_b_wr,
    output logic [ADDR-1:0]  ram_b_addr,
    output logic [OUT_W-1:0] ram_b_din,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    output logic             dout_last,
    output logic             ovf,
    output logic [31:0]      acc_cnt
);

    state_t state;
    state_t state_nx;
    logic   run;
    logic   accept;

    logic [ADDR-1:0] idx;
    logic            first;
    logic            last;
    logic            idx_last;

    logic            v1;
    logic [ADDR-1:0] idx1;
    logic [IN_W-1:0] d1;
    logic            first1;
    logic            last1;
    logic            il1;

    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] sum;
    logic             add_ovf;
    logic             ovf_now;
    logic             sticky;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sync_in) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        run    = (state == RUN);
        accept = run && din_valid && !sync_in;
    end

    vacc_counters #(
        .ADDR(ADDR)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync     (sync_in),
        .valid    (run && din_valid),
        .acc_len  (acc_len),
        .idx      (idx),
        .first    (first),
        .last     (last),
        .idx_last (idx_last)
    );

    assign ram_a_addr = idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            idx1   <= '0;
            d1     <= '0;
            first1 <= 1'b0;
            last1  <= 1'b0;
            il1    <= 1'b0;
        end else begin
            v1     <= accept;
            idx1   <= idx;
            d1     <= din;
            first1 <= first;
            last1  <= last;
            il1    <= idx_last;
        end
    end

    // First vector overwrites stale RAM content instead of adding to it.
    always_comb begin
        ext     = OUT_W'(sext({{(64 - IN_W){1'b0}}, d1}, IN_W));
        acc     = ram_a_dout + ext;
        add_ovf = (ram_a_dout[OUT_W-1] == ext[OUT_W-1]) &&
                  (acc[OUT_W-1] != ram_a_dout[OUT_W-1]);
        sum     = first1 ? ext : acc;
        ovf_now = first1 ? 1'b0 : (sticky | add_ovf);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky     <= 1'b0;
            ram_b_wr   <= 1'b0;
            ram_b_addr <= '0;
            ram_b_din  <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            ovf        <= 1'b0;
            acc_cnt    <= '0;
        end else begin
            ram_b_wr   <= v1;
            ram_b_addr <= idx1;
            ram_b_din  <= sum;
            dout_valid <= v1 && last1;
            dout_last  <= v1 && last1 && il1;
            if (v1) begin
                sticky <= ovf_now;
            end
            if (v1 && last1) begin
                dout <= sum;
                ovf  <= ovf_now;
            end
            if (v1 && last1 && il1) begin
                acc_cnt <= acc_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_vacc_ctrl.sv
// Randomized bench for vacc_ctrl against a sample-level accumulation model.
module tb_vacc_ctrl;

    localparam int IN_W  = 8;
    localparam int OUT_W = 16;
    localparam int ADDR  = 2;
    localparam int VL    = 4;

    logic             clk;
    logic             rst_n;
    logic             sync_in;
    logic [31:0]      acc_len;
    logic             din_valid;
    logic [IN_W-1:0]  din;
    logic [ADDR-1:0]  ram_a_addr;
    logic [OUT_W-1:0] ram_a_dout;
    logic             ram_b_wr;
    logic [ADDR-1:0]  ram_b_addr;
    logic [OUT_W-1:0] ram_b_din;
    logic [OUT_W-1:0] dout;
    logic             dout_valid;
    logic             dout_last;
    logic             ovf;
    logic [31:0]      acc_cnt;

    vacc_ctrl #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .ADDR (ADDR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_in   (sync_in),
        .acc_len   (acc_len),
        .din_valid (din_valid),
        .din       (din),
        .ram_a_addr(ram_a_addr),
        .ram_a_dout(ram_a_dout),
        .ram_b_wr  (ram_b_wr),
        .ram_b_addr(ram_b_addr),
        .ram_b_din (ram_b_din),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_last (dout_last),
        .ovf       (ovf),
        .acc_cnt   (acc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [OUT_W-1:0] ram [VL];
    logic             preload;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < VL; i++) ram[i] <= 16'h7777;
        end else if (ram_b_wr) begin
            ram[ram_b_addr] <= ram_b_din;
        end
        ram_a_dout <= ram[ram_a_addr];
    end

    typedef struct {
        int d;
        bit l;
        bit o;
        int c;
    } exp_t;

    exp_t expq[$];
    int   cap_d[$];
    bit   cap_l[$];
    bit   cap_o[$];
    int   cap_c[$];

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    // Model state: sample count since sync, integration length, running sums.
    bit running;
    int n;
    int len_m;
    int sums[VL];
    bit sticky;
    int exp_cnt;

    task automatic accept(input int x);
        int bin, vec, t;
        logic [31:0] tv;
        logic signed [15:0] w;
        exp_t e;
        bin = n % VL;
        vec = (n / VL) % len_m;
        if (vec == 0) begin
            sums[bin] = x;
            sticky = 1'b0;
        end else begin
            t = sums[bin] + x;
            if (t > 32767 || t < -32768) sticky = 1'b1;
            tv = t;
            w = tv[15:0];
            sums[bin] = int'(w);
        end
        n++;
        if (vec == len_m - 1) begin
            e.d = sums[bin];
            e.l = (bin == VL - 1);
            if (e.l) exp_cnt++;
            e.o = sticky;
            e.c = exp_cnt;
            expq.push_back(e);
        end
    endtask

    always @(negedge clk) begin : cmp
        exp_t e;
        if (rst_n && dout_valid) begin
            cap_d.push_back(int'($signed(dout)));
            cap_l.push_back(dout_last);
            cap_o.push_back(ovf);
            cap_c.push_back(int'(acc_cnt));
            if (expq.size() == 0) begin
                chk("unexpected_dout", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("dout", $signed(dout), e.d);
                chk("dout_last", dout_last, e.l);
                chk("ovf", ovf, e.o);
                if (e.l) chk("acc_cnt", acc_cnt, e.c);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int x);
        logic [31:0] xv;
        xv = x;
        din_valid = v;
        din = xv[IN_W-1:0];
        if (v && running) accept(x);
        tick();
        din_valid = 1'b0;
    endtask

    task automatic do_sync(input int len, input bit coinc);
        sync_in = 1'b1;
        acc_len = len;
        din_valid = coinc;
        din = 8'h55;
        running = 1'b1;
        n = 0;
        len_m = (len == 0) ? 1 : len;
        tick();
        sync_in = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic clear_cap();
        cap_d.delete();
        cap_l.delete();
        cap_o.delete();
        cap_c.delete();
    endtask

    task automatic model_reset();
        expq.delete();
        exp_cnt = 0;
        running = 1'b0;
        n = 0;
        sticky = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        sync_in = 1'b0;
        acc_len = 32'd0;
        din_valid = 1'b0;
        din = '0;
        preload = 1'b0;
        len_m = 1;
        model_reset();
        tick();
        tick();
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_ram_b_wr", ram_b_wr, 0);
        chk("rst_acc_cnt", acc_cnt, 0);
        chk("rst_dout", dout, 0);
        rst_n = 1'b1;
        tick();

        // 1: pass-through with acc_len=1 and 2-cycle latency
        clear_cap();
        do_sync(1, 1'b0);
        drive(1'b1, 1);
        chk("lat_t1", dout_valid, 0);
        tick();
        chk("lat_t2", dout_valid, 1);
        drive(1'b1, 2);
        drive(1'b1, 3);
        drive(1'b1, 4);
        drain();
        chk("t1_count", cap_d.size(), 4);
        for (int i = 0; i < 4 && i < cap_d.size(); i++)
            chk("t1_dout", cap_d[i], i + 1);
        if (cap_d.size() == 4) begin
            chk("t1_last0", cap_l[0], 0);
            chk("t1_last3", cap_l[3], 1);
            chk("t1_ovf", cap_o[3], 0);
            chk("t1_acc_cnt", cap_c[3], 1);
        end

        // 2: stale RAM ignored by first vector
        preload = 1'b1;
        tick();
        preload = 1'b0;
        clear_cap();
        do_sync(3, 1'b0);
        for (int i = 0; i < 12; i++) drive(1'b1, 5);
        drain();
        chk("t2_count", cap_d.size(), 4);
        foreach (cap_d[i]) chk("t2_dout", cap_d[i], 15);

        // 3: negative full-scale
        clear_cap();
        do_sync(2, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b1, -128);
        drain();
        chk("t3_count", cap_d.size(), 4);
        foreach (cap_d[i]) chk("t3_dout", cap_d[i], -256);

        // 4: wraparound with sticky overflow, then clean integration
        clear_cap();
        do_sync(300, 1'b0);
        for (int i = 0; i < 1200; i++) drive(1'b1, 127);
        drain();
        chk("t4_count", cap_d.size(), 4);
        if (cap_d.size() == 4) begin
            chk("t4_dout", cap_d[0], -27436);
            chk("t4_ovf", cap_o[3], 1);
        end
        clear_cap();
        for (int i = 0; i < 1200; i++) drive(1'b1, 1);
        drain();
        chk("t4b_count", cap_d.size(), 4);
        if (cap_d.size() == 4) begin
            chk("t4b_dout", cap_d[3], 300);
            chk("t4b_ovf", cap_o[3], 0);
        end

        // 5: abort mid-integration, restart at bin 0
        clear_cap();
        do_sync(3, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, 7);
        drain();
        chk("t5_abort_quiet", cap_d.size(), 0);
        do_sync(3, 1'b1);
        for (int v = 0; v < 3; v++)
            for (int b = 0; b < 4; b++) drive(1'b1, b + 10);
        drain();
        chk("t5_count", cap_d.size(), 4);
        for (int i = 0; i < 4 && i < cap_d.size(); i++)
            chk("t5_dout", cap_d[i], 3 * (i + 10));

        // 6: scenario 2 with random bubbles
        clear_cap();
        do_sync(3, 1'b0);
        for (int sent = 0; sent < 12;) begin
            if ($urandom_range(1, 0) == 1) begin
                drive(1'b1, 5);
                sent++;
            end else begin
                drive(1'b0, int'($urandom_range(255, 0)) - 128);
            end
        end
        drain();
        chk("t6_count", cap_d.size(), 4);
        foreach (cap_d[i]) chk("t6_dout", cap_d[i], 15);

        // Random lengths, data, bubbles, coincident and mid-run syncs
        for (int r = 0; r < 12; r++) begin
            int len, tot;
            len = $urandom_range(4, 0);
            do_sync(len, 1'($urandom_range(1, 0)));
            tot = ((len == 0) ? 1 : len) * VL * $urandom_range(2, 1)
                  + $urandom_range(5, 0);
            for (int sent = 0; sent < tot;) begin
                if ($urandom_range(1, 0) == 1) begin
                    drive(1'b1, int'($urandom_range(255, 0)) - 128);
                    sent++;
                end else begin
                    drive(1'b0, 0);
                end
            end
        end
        drain();

        // 7: reset mid-integration
        do_sync(3, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 9);
        rst_n = 1'b0;
        tick();
        model_reset();
        chk("t7_ram_b_wr", ram_b_wr, 0);
        chk("t7_ram_b_addr", ram_b_addr, 0);
        chk("t7_ram_b_din", ram_b_din, 0);
        chk("t7_dout", dout, 0);
        chk("t7_dout_valid", dout_valid, 0);
        chk("t7_dout_last", dout_last, 0);
        chk("t7_ovf", ovf, 0);
        chk("t7_acc_cnt", acc_cnt, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 3);
            chk("t7_idle_wr", ram_b_wr, 0);
            chk("t7_idle_dv", dout_valid, 0);
        end
        clear_cap();
        do_sync(1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 20 - i);
        drain();
        chk("t7_count", cap_d.size(), 4);
        if (cap_d.size() == 4) begin
            chk("t7_d0", cap_d[0], 20);
            chk("t7_cnt", cap_c[3], 1);
        end

        chk("queue_empty", expq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
